// File: rtl/banco_registradores_2r1w.sv
// Register file with two registered read ports and one byte-masked write port.
// After each reset a clear sweep zeroes the array and loads one preset entry.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_SWEEP | clear sweep running; busy=1, accesses ignored, read data held 0
// ST_IDLE  | normal operation; reads and writes accepted
module banco_registradores_2r1w #(
   parameter int DATA_W    = 64,
   parameter int ADDR_W    = 5,
   parameter int ZERO_REG  = 1,
   parameter int INIT_ADDR = 16,
   parameter int INIT_VAL  = 45
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_we,
   input  logic [DATA_W/8-1:0]   i_be,
   input  logic [ADDR_W-1:0]     i_ads_w,
   input  logic [DATA_W-1:0]     i_din,
   input  logic                  i_re_a,
   input  logic [ADDR_W-1:0]     i_ads_a,
   output logic [DATA_W-1:0]     o_dout_a,
   input  logic                  i_re_b,
   input  logic [ADDR_W-1:0]     i_ads_b,
   output logic [DATA_W-1:0]     o_dout_b,
   output logic                  o_busy
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int NB    = DATA_W / 8;
   localparam logic [DATA_W-1:0] INIT_WORD = DATA_W'(INIT_VAL);
   localparam logic [ADDR_W-1:0] INIT_IDX  = ADDR_W'(INIT_ADDR);

   typedef enum logic {ST_SWEEP, ST_IDLE} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_cnt;
   logic [ADDR_W-1:0]   w_cnt_nxt;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [DATA_W-1:0]   r_dout_a;
   logic [DATA_W-1:0]   r_dout_b;
   logic [DATA_W-1:0]   w_merged;
   logic [DATA_W-1:0]   w_rd_a;
   logic [DATA_W-1:0]   w_rd_b;
   logic [DATA_W-1:0]   w_sweep_word;
   logic                w_wr_en;
   logic                w_busy;

   // Next-state and sweep counter: leave the sweep after the last entry is cleared.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_busy      = 1'b0;
      case (r_state)
         ST_SWEEP: begin
            w_busy = 1'b1;
            if (&r_cnt) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_IDLE: begin
            w_busy = 1'b0;
         end
         default: begin
            w_state_nxt = ST_SWEEP;
            w_busy      = 1'b1;
         end
      endcase
   end

   // Write merge, write qualification and write-first read selection for both ports.
   always_comb begin
      w_merged = r_mem[i_ads_w];
      for (int b = 0; b < NB; b++) begin
         if (i_be[b]) begin
            w_merged[8*b +: 8] = i_din[8*b +: 8];
         end
      end
      w_sweep_word = (r_cnt == INIT_IDX) ? INIT_WORD : '0;
      w_wr_en = (r_state == ST_IDLE) && i_we &&
                !((ZERO_REG != 0) && (i_ads_w == '0));

      if ((ZERO_REG != 0) && (i_ads_a == '0)) begin
         w_rd_a = '0;
      end else if (i_we && (i_ads_w == i_ads_a)) begin
         w_rd_a = w_merged;
      end else begin
         w_rd_a = r_mem[i_ads_a];
      end

      if ((ZERO_REG != 0) && (i_ads_b == '0)) begin
         w_rd_b = '0;
      end else if (i_we && (i_ads_w == i_ads_b)) begin
         w_rd_b = w_merged;
      end else begin
         w_rd_b = r_mem[i_ads_b];
      end
   end

   // State, counter and read-port registers; reset restarts the sweep.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_SWEEP;
         r_cnt    <= '0;
         r_dout_a <= '0;
         r_dout_b <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (r_state == ST_SWEEP) begin
            r_dout_a <= '0;
            r_dout_b <= '0;
         end else begin
            if (i_re_a) r_dout_a <= w_rd_a;
            if (i_re_b) r_dout_b <= w_rd_b;
         end
      end
   end

   // Array storage: sweep clears/presets, otherwise accepted writes land; reset cycle leaves it alone.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         if (r_state == ST_SWEEP) begin
            r_mem[r_cnt] <= w_sweep_word;
         end else if (w_wr_en) begin
            r_mem[i_ads_w] <= w_merged;
         end
      end
   end

   assign o_dout_a = r_dout_a;
   assign o_dout_b = r_dout_b;
   assign o_busy   = w_busy;

endmodule
